// File: rtl/alu_issue_unit.sv
// Execute-stage issue unit: reads operands from an 8x16 register file, drives an
// external combinational ALU for ALU_WAIT+1 cycles, then writes the result back.
module alu_issue_unit #(
  parameter int unsigned ALU_WAIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic [2:0]  dbg_addr,
  output logic [15:0] dbg_data,
  output logic [15:0] Alu_inputA,
  output logic [15:0] Alu_inputB,
  output logic [2:0]  Alu_control,
  input  logic [15:0] Alu_result,
  input  logic        Zero,
  output logic        done,
  output logic [15:0] result_out,
  output logic        zero_flag
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(ALU_WAIT);

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_rf [8];
  logic [3:0]  r_cnt;
  logic [2:0]  r_rd;
  logic [15:0] r_alu_a;
  logic [15:0] r_alu_b;
  logic [2:0]  r_alu_ctl;
  logic [15:0] r_result;
  logic        r_zero;

  logic [2:0]  w_op;
  logic [2:0]  w_rd;
  logic [2:0]  w_rs;
  logic [2:0]  w_rt;
  logic        w_use_imm;
  logic [2:0]  w_imm;
  logic        w_accept;
  logic        w_wb;
  logic        w_host_we;
  logic [15:0] w_opnd_b;

  assign w_op      = instr[15:13];
  assign w_rd      = instr[12:10];
  assign w_rs      = instr[9:7];
  assign w_rt      = instr[6:4];
  assign w_use_imm = instr[3];
  assign w_imm     = instr[2:0];

  assign w_accept  = (r_state == S_IDLE) && instr_valid;
  assign w_wb      = (r_state == S_EXEC) && (r_cnt == 4'd0);
  assign w_host_we = (r_state == S_IDLE) && wr_en && (wr_addr != 3'd0);
  assign w_opnd_b  = w_use_imm ? {13'b0, w_imm} : r_rf[w_rt];

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (instr_valid) w_state_next = S_EXEC;
      S_EXEC:  if (r_cnt == 4'd0) w_state_next = S_WB;
      S_WB:    w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // The ALU operands are only touched on accept, so they stay frozen through EXEC and WB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= 4'd0;
      r_rd      <= 3'd0;
      r_alu_a   <= 16'd0;
      r_alu_b   <= 16'd0;
      r_alu_ctl <= 3'd0;
    end else if (w_accept) begin
      r_cnt     <= WAIT_INIT;
      r_rd      <= w_rd;
      r_alu_a   <= r_rf[w_rs];
      r_alu_b   <= w_opnd_b;
      r_alu_ctl <= w_op;
    end else if (r_state == S_EXEC && r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result <= 16'd0;
      r_zero   <= 1'b0;
    end else if (w_wb) begin
      r_result <= Alu_result;
      r_zero   <= Zero;
    end
  end

  // r0 is never written, so it holds its reset value of zero forever.
  // Host writes (IDLE only) and write-back (EXEC only) can never coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        r_rf[i] <= 16'd0;
      end
    end else if (w_wb) begin
      if (r_rd != 3'd0) begin
        r_rf[r_rd] <= Alu_result;
      end
    end else if (w_host_we) begin
      r_rf[wr_addr] <= wr_data;
    end
  end

  assign dbg_data    = (dbg_addr == 3'd0) ? 16'd0 : r_rf[dbg_addr];
  assign instr_ready = (r_state == S_IDLE);
  assign done        = (r_state == S_WB);
  assign Alu_inputA  = r_alu_a;
  assign Alu_inputB  = r_alu_b;
  assign Alu_control = r_alu_ctl;
  assign result_out  = r_result;
  assign zero_flag   = r_zero;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: two instances (ALU_WAIT=0 and 3), a bench-side ALU,
// a latency-based reference model compared every cycle, plus directed literal checks.
module tb_alu_issue_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        instr_valid [2];
  logic [15:0] instr       [2];
  logic        instr_ready [2];
  logic        wr_en       [2];
  logic [2:0]  wr_addr     [2];
  logic [15:0] wr_data     [2];
  logic [2:0]  dbg_addr    [2];
  logic [15:0] dbg_data    [2];
  logic [15:0] alu_a       [2];
  logic [15:0] alu_b       [2];
  logic [2:0]  alu_ctl     [2];
  logic [15:0] alu_res     [2];
  logic        alu_zero    [2];
  logic        done        [2];
  logic [15:0] result_out  [2];
  logic        zero_flag   [2];

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;

  always #5 clk = ~clk;

  function automatic logic [15:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                         input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      default: return a;
    endcase
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_inst
      localparam int W = gi * 3;

      alu_issue_unit #(.ALU_WAIT(W)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid[gi]),
        .instr       (instr[gi]),
        .instr_ready (instr_ready[gi]),
        .wr_en       (wr_en[gi]),
        .wr_addr     (wr_addr[gi]),
        .wr_data     (wr_data[gi]),
        .dbg_addr    (dbg_addr[gi]),
        .dbg_data    (dbg_data[gi]),
        .Alu_inputA  (alu_a[gi]),
        .Alu_inputB  (alu_b[gi]),
        .Alu_control (alu_ctl[gi]),
        .Alu_result  (alu_res[gi]),
        .Zero        (alu_zero[gi]),
        .done        (done[gi]),
        .result_out  (result_out[gi]),
        .zero_flag   (zero_flag[gi])
      );

      assign alu_res[gi]  = alu_fn(alu_a[gi], alu_b[gi], alu_ctl[gi]);
      assign alu_zero[gi] = (alu_res[gi] == 16'd0);

      // Reference model: busy for W+2 edges after an accept; write-back and done at edge W+1.
      logic [15:0] m_rf [8];
      logic [15:0] m_a, m_b, m_res, m_r;
      logic [2:0]  m_op, m_rd;
      logic        m_z, m_done, m_busy;
      int          m_el;

      always @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < 8; i++) m_rf[i] = 16'd0;
          m_a = 0; m_b = 0; m_res = 0; m_op = 0; m_rd = 0;
          m_z = 0; m_done = 0; m_busy = 0; m_el = 0;
        end else if (!m_busy) begin
          if (instr_valid[gi]) begin
            m_op   = instr[gi][15:13];
            m_rd   = instr[gi][12:10];
            m_a    = m_rf[instr[gi][9:7]];
            m_b    = instr[gi][3] ? {13'b0, instr[gi][2:0]} : m_rf[instr[gi][6:4]];
            m_busy = 1;
            m_el   = 0;
          end
          if (wr_en[gi] && wr_addr[gi] != 3'd0) m_rf[wr_addr[gi]] = wr_data[gi];
        end else begin
          m_el++;
          if (m_el == W + 1) begin
            m_r = alu_fn(m_a, m_b, m_op);
            if (m_rd != 3'd0) m_rf[m_rd] = m_r;
            m_res  = m_r;
            m_z    = (m_r == 16'd0);
            m_done = 1;
          end else if (m_el == W + 2) begin
            m_done = 0;
            m_busy = 0;
          end
        end
      end

      always @(negedge clk) begin
        if (!rst) begin
          chk($sformatf("u%0d_ready", gi), 16'(instr_ready[gi]), 16'(!m_busy));
          chk($sformatf("u%0d_done", gi), 16'(done[gi]), 16'(m_done));
          chk($sformatf("u%0d_result", gi), result_out[gi], m_res);
          chk($sformatf("u%0d_zflag", gi), 16'(zero_flag[gi]), 16'(m_z));
          chk($sformatf("u%0d_aluA", gi), alu_a[gi], m_a);
          chk($sformatf("u%0d_aluB", gi), alu_b[gi], m_b);
          chk($sformatf("u%0d_aluctl", gi), 16'(alu_ctl[gi]), 16'(m_op));
          chk($sformatf("u%0d_dbg", gi), dbg_data[gi], m_rf[dbg_addr[gi]]);
        end
      end
    end
  endgenerate

  task automatic wait_ready(input int i);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (instr_ready[i]) break;
    end
    chk("ready_wait", 16'(instr_ready[i]), 16'd1);
    #1;
  endtask

  task automatic hwrite(input int i, input logic [2:0] a, input logic [15:0] d);
    wait_ready(i);
    wr_en[i] = 1'b1; wr_addr[i] = a; wr_data[i] = d;
    @(posedge clk); #1;
    wr_en[i] = 1'b0;
  endtask

  // wmode: 0 no host write, 1 host write on the accept edge, 2 host write during EXEC.
  task automatic issue(input int i, input logic [2:0] op, input logic [2:0] rd,
                       input logic [2:0] rs, input logic [2:0] rt, input logic ui,
                       input logic [2:0] imm, input int wmode, input logic [2:0] wa,
                       input logic [15:0] wd, output int lat);
    wait_ready(i);
    instr[i] = {op, rd, rs, rt, ui, imm};
    instr_valid[i] = 1'b1;
    wr_addr[i] = wa; wr_data[i] = wd;
    wr_en[i] = (wmode == 1);
    @(posedge clk); #1;
    instr_valid[i] = 1'b0;
    wr_en[i] = (wmode == 2);
    lat = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      lat++;
      if (lat >= 2) wr_en[i] = 1'b0;
      if (done[i]) break;
    end
    wr_en[i] = 1'b0;
    chk("done_seen", 16'(done[i]), 16'd1);
    #1;
  endtask

  task automatic dbg(input int i, input logic [2:0] a, input logic [15:0] exp, input string name);
    dbg_addr[i] = a;
    #1;
    chk(name, dbg_data[i], exp);
  endtask

  int lat;

  initial begin
    for (int i = 0; i < 2; i++) begin
      instr_valid[i] = 0; instr[i] = 0; wr_en[i] = 0;
      wr_addr[i] = 0; wr_data[i] = 0; dbg_addr[i] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_ready", 16'(instr_ready[i]), 16'd1);
      chk("rst_done", 16'(done[i]), 16'd0);
      chk("rst_result", result_out[i], 16'd0);
      chk("rst_aluA", alu_a[i], 16'd0);
    end

    // ALU_WAIT = 0
    hwrite(0, 3'd1, 16'hAB03);
    hwrite(0, 3'd2, 16'h32FF);
    hwrite(0, 3'd0, 16'hFFFF);
    dbg(0, 3'd0, 16'h0000, "r0_host_drop");
    issue(0, OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0, 3'd0, 0, 3'd0, 16'd0, lat);
    chk("add_lat", 16'(lat), 16'd2);
    chk("add_result", result_out[0], 16'hDE02);
    chk("add_zflag", 16'(zero_flag[0]), 16'd0);
    dbg(0, 3'd3, 16'hDE02, "add_r3");
    issue(0, OP_SUB, 3'd4, 3'd1, 3'd2, 1'b0, 3'd0, 0, 3'd0, 16'd0, lat);
    chk("sub_result", result_out[0], 16'h7804);
    chk("sub_zflag", 16'(zero_flag[0]), 16'd0);
    dbg(0, 3'd4, 16'h7804, "sub_r4");
    issue(0, OP_SUB, 3'd5, 3'd1, 3'd1, 1'b0, 3'd0, 0, 3'd0, 16'd0, lat);
    chk("subz_result", result_out[0], 16'h0000);
    chk("subz_zflag", 16'(zero_flag[0]), 16'd1);
    dbg(0, 3'd5, 16'h0000, "subz_r5");
    issue(0, OP_ADD, 3'd6, 3'd1, 3'd0, 1'b1, 3'd4, 0, 3'd0, 16'd0, lat);
    chk("imm_aluB", alu_b[0], 16'h0004);
    dbg(0, 3'd6, 16'hAB07, "imm_r6");
    issue(0, OP_ADD, 3'd0, 3'd1, 3'd0, 1'b1, 3'd4, 0, 3'd0, 16'd0, lat);
    chk("r0wb_result", result_out[0], 16'hAB07);
    dbg(0, 3'd0, 16'h0000, "r0wb_dbg");
    issue(0, OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0, 3'd0, 1, 3'd1, 16'h0001, lat);
    dbg(0, 3'd3, 16'hDE02, "collide_r3");
    dbg(0, 3'd1, 16'h0001, "collide_r1");

    // ALU_WAIT = 3
    hwrite(1, 3'd1, 16'hAB03);
    hwrite(1, 3'd2, 16'h32FF);
    issue(1, OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0, 3'd0, 0, 3'd0, 16'd0, lat);
    chk("w3_lat", 16'(lat), 16'd5);
    chk("w3_result", result_out[1], 16'hDE02);
    issue(1, OP_ADD, 3'd5, 3'd1, 3'd2, 1'b0, 3'd0, 2, 3'd7, 16'h1234, lat);
    dbg(1, 3'd7, 16'h0000, "exec_write_drop");
    dbg(1, 3'd5, 16'hDE02, "w3_r5");

    wait_ready(1);
    instr[1] = {OP_ADD, 3'd6, 3'd1, 3'd2, 1'b0, 3'd0};
    instr_valid[1] = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    instr_valid[1] = 1'b0;
    wait_ready(1);
    dbg(1, 3'd6, 16'hDE02, "b2b_r6");

    // Reset during the second EXEC cycle
    wait_ready(1);
    instr[1] = {OP_SUB, 3'd4, 3'd1, 3'd2, 1'b0, 3'd0};
    instr_valid[1] = 1'b1;
    dbg_addr[1] = 3'd1;
    @(posedge clk); #1;
    instr_valid[1] = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("mrst_done", 16'(done[1]), 16'd0);
    chk("mrst_ready", 16'(instr_ready[1]), 16'd1);
    chk("mrst_result", result_out[1], 16'd0);
    chk("mrst_aluA", alu_a[1], 16'd0);
    chk("mrst_aluB", alu_b[1], 16'd0);
    chk("mrst_r1", dbg_data[1], 16'd0);
    chk("mrst_u0_result", result_out[0], 16'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    dbg(1, 3'd4, 16'h0000, "mrst_r4");
    issue(1, OP_ADD, 3'd3, 3'd1, 3'd0, 1'b1, 3'd5, 0, 3'd0, 16'd0, lat);
    chk("post_rst_result", result_out[1], 16'h0005);
    dbg(1, 3'd3, 16'h0005, "post_rst_r3");

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
